mips_multicycle_ctrl: RTL and testbench

Control FSM for the multi-cycle MIPS core. It sequences a single shared ALU, register file and unified memory port through FETCH / DECODE / EXEC / MEM / WB for ADDU, ADDI, LW, SW, BEQ and J. It sits beside the instruction register and drives every datapath strobe. A memory-handshake watchdog halts the core on a bus hang.

---
 rtl/mips_ctrl_pkg.sv | 56 +++++
 rtl/mips_multicycle_ctrl_ack_watchdog.sv | 27 ++
 rtl/mips_multicycle_ctrl.sv | 162 ++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared types, opcode constants and opcode classifier for the multi-cycle control FSM
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;

  localparam logic [11:0] ADD_OP  = {OP_RTYPE, FN_ADDU};
  localparam logic [11:0] SUB_OP  = {OP_RTYPE, FN_SUBU};
  localparam logic [11:0] ADDI_OP = {OP_ADDI, 6'b000000};

  typedef enum logic [1:0] {
    PC_SRC_ALU    = 2'b00,
    PC_SRC_ALUOUT = 2'b01,
    PC_SRC_JUMP   = 2'b10
  } pc_src_t;

  typedef enum logic [1:0] {
    SRC_B_RT      = 2'b00,
    SRC_B_FOUR    = 2'b01,
    SRC_B_IMM     = 2'b10,
    SRC_B_IMM_SH2 = 2'b11
  } alu_src_b_t;

  typedef enum logic [2:0] {
    CLS_ADDU, CLS_ADDI, CLS_LW, CLS_SW, CLS_BEQ, CLS_J, CLS_ILLEGAL
  } op_class_t;

  function automatic op_class_t classify(input logic [5:0] opcode, input logic [5:0] func);
    case (opcode)
      OP_RTYPE: return (func == FN_ADDU) ? CLS_ADDU : CLS_ILLEGAL;
      OP_ADDI:  return CLS_ADDI;
      OP_LW:    return CLS_LW;
      OP_SW:    return CLS_SW;
      OP_BEQ:   return CLS_BEQ;
      OP_J:     return CLS_J;
      default:  return CLS_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_ack_watchdog.sv
// rtl/mips_multicycle_ctrl_ack_watchdog.sv - memory handshake watchdog counting unacknowledged request cycles
module ack_watchdog #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic mem_ack,
  output logic expired
);

  logic [7:0] count;

  // Leaving FETCH/MEM always passes through an ack or an idle state, so either one clears the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (!active || mem_ack) begin
      count <= '0;
    end else begin
      count <= count + 8'd1;
    end
  end

  assign expired = active && !mem_ack && (count == 8'(ACK_TIMEOUT));

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multi-cycle MIPS control FSM driving all datapath strobes
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic [5:0]  func,
  input  logic        zero,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_iord,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        reg_we,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [11:0] alu_control,
  output logic [2:0]  state_o,
  output logic        illegal,
  output logic        bus_err
);

  state_t    state, state_next;
  op_class_t cls_q, cls_dec;
  logic      bus_err_q;
  logic      wd_active, wd_expired;

  assign cls_dec   = classify(opcode, func);
  assign wd_active = (state == S_FETCH) || (state == S_MEM);

  ack_watchdog #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .active  (wd_active),
    .mem_ack (mem_ack),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_FETCH;
      cls_q     <= CLS_ILLEGAL;
      bus_err_q <= 1'b0;
    end else begin
      state <= state_next;
      if (state == S_DECODE) cls_q <= cls_dec;
      if (state_next == S_HALT) bus_err_q <= 1'b1;
    end
  end

  always_comb begin
    state_next  = state;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_iord    = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    pc_src      = PC_SRC_ALU;
    reg_we      = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = SRC_B_RT;
    alu_control = ADD_OP;
    illegal     = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRC_B_FOUR;
        if (mem_ack) begin
          ir_we      = 1'b1;
          pc_we      = 1'b1;
          state_next = S_DECODE;
        end else if (wd_expired) begin
          state_next = S_HALT;
        end
      end
      S_DECODE: begin
        alu_src_b = SRC_B_IMM_SH2;
        case (cls_dec)
          CLS_J: begin
            pc_we      = 1'b1;
            pc_src     = PC_SRC_JUMP;
            state_next = S_FETCH;
          end
          CLS_ILLEGAL: begin
            illegal    = 1'b1;
            state_next = S_FETCH;
          end
          default: state_next = S_EXEC;
        endcase
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        case (cls_q)
          CLS_ADDU: state_next = S_WB;
          CLS_ADDI: begin
            alu_src_b   = SRC_B_IMM;
            alu_control = ADDI_OP;
            state_next  = S_WB;
          end
          CLS_LW, CLS_SW: begin
            alu_src_b  = SRC_B_IMM;
            state_next = S_MEM;
          end
          CLS_BEQ: begin
            alu_control = SUB_OP;
            pc_src      = PC_SRC_ALUOUT;
            pc_we       = zero;
            state_next  = S_FETCH;
          end
          default: state_next = S_FETCH;
        endcase
      end
      S_MEM: begin
        mem_req  = 1'b1;
        mem_iord = 1'b1;
        mem_we   = (cls_q == CLS_SW);
        if (mem_ack) begin
          state_next = (cls_q == CLS_LW) ? S_WB : S_FETCH;
        end else if (wd_expired) begin
          state_next = S_HALT;
        end
      end
      S_WB: begin
        reg_we     = 1'b1;
        reg_dst    = (cls_q == CLS_ADDU);
        mem_to_reg = (cls_q == CLS_LW);
        state_next = S_FETCH;
      end
      S_HALT:  state_next = S_HALT;
      default: state_next = S_FETCH;
    endcase
    // Reset kills any in-flight request immediately; the memory side discards it.
    if (rst) begin
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      mem_iord    = 1'b0;
      ir_we       = 1'b0;
      pc_we       = 1'b0;
      pc_src      = 2'b00;
      reg_we      = 1'b0;
      reg_dst     = 1'b0;
      mem_to_reg  = 1'b0;
      alu_src_a   = 1'b0;
      alu_src_b   = 2'b00;
      alu_control = 12'd0;
      illegal     = 1'b0;
    end
  end

  assign state_o = rst ? 3'd0 : state;
  assign bus_err = bus_err_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - randomized self-checking bench for the multi-cycle control FSM
module tb_mips_multicycle_ctrl;

  localparam int TO = 4;
  localparam logic [2:0] ST_F = 3'd0, ST_D = 3'd1, ST_E = 3'd2, ST_M = 3'd3, ST_W = 3'd4, ST_H = 3'd5;
  localparam logic [11:0] ADD = 12'b000000_100001, SUB = 12'b000000_100011, ADDI = 12'b001000_000000;
  localparam int C_ADDU = 0, C_ADDI = 1, C_LW = 2, C_SW = 3, C_BEQ = 4, C_J = 5, C_ILL = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  opcode = '0, func = '0;
  logic        zero = 1'b0, mem_ack = 1'b0;
  logic        mem_req, mem_we, mem_iord, ir_we, pc_we, reg_we, reg_dst, mem_to_reg, alu_src_a;
  logic        illegal, bus_err;
  logic [1:0]  pc_src, alu_src_b;
  logic [11:0] alu_control;
  logic [2:0]  state_o;
  logic [29:0] act;

  int passed = 0;
  int total  = 0;

  mips_multicycle_ctrl #(.ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func(func), .zero(zero), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_iord(mem_iord), .ir_we(ir_we), .pc_we(pc_we),
    .pc_src(pc_src), .reg_we(reg_we), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .state_o(state_o), .illegal(illegal), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  assign act = {state_o, mem_req, mem_we, mem_iord, ir_we, pc_we, pc_src, reg_we, reg_dst,
                mem_to_reg, alu_src_a, alu_src_b, alu_control, illegal, bus_err};

  typedef struct {
    bit          ack;
    bit          z;
    bit          dec;
    logic [29:0] e;
  } cyc_t;

  function automatic logic [29:0] ev(input logic [2:0] st, input bit mreq, mwe, iord, irwe, pcwe,
                                     input logic [1:0] pcs, input bit rwe, rdst, m2r, sa,
                                     input logic [1:0] sb, input logic [11:0] alu, input bit ill, berr);
    return {st, mreq, mwe, iord, irwe, pcwe, pcs, rwe, rdst, m2r, sa, sb, alu, ill, berr};
  endfunction

  function automatic int cls_of(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'b000000) return (fn == 6'b100001) ? C_ADDU : C_ILL;
    if (op == 6'b001000) return C_ADDI;
    if (op == 6'b100011) return C_LW;
    if (op == 6'b101011) return C_SW;
    if (op == 6'b000100) return C_BEQ;
    if (op == 6'b000010) return C_J;
    return C_ILL;
  endfunction

  // Expected per-cycle trace from the instruction's phase list; zsel 2 means random zero.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fwait, input int mwait,
                           input int zsel, input string name);
    cyc_t q[$];
    int   c;
    bit   zb;
    c  = cls_of(op, fn);
    zb = (zsel == 2) ? 1'($urandom) : (zsel == 1);
    for (int i = 0; i < fwait; i++)
      q.push_back('{1'b0, 1'($urandom), 1'b0, ev(ST_F,1,0,0,0,0,2'b00,0,0,0,0,2'b01,ADD,0,0)});
    q.push_back('{1'b1, 1'($urandom), 1'b0, ev(ST_F,1,0,0,1,1,2'b00,0,0,0,0,2'b01,ADD,0,0)});
    q.push_back('{1'($urandom), 1'($urandom), 1'b1,
                  ev(ST_D,0,0,0,0,c == C_J,(c == C_J) ? 2'b10 : 2'b00,0,0,0,0,2'b11,ADD,c == C_ILL,0)});
    if (c == C_ADDU)
      q.push_back('{1'($urandom), 1'($urandom), 1'b0, ev(ST_E,0,0,0,0,0,2'b00,0,0,0,1,2'b00,ADD,0,0)});
    if (c == C_ADDI)
      q.push_back('{1'($urandom), 1'($urandom), 1'b0, ev(ST_E,0,0,0,0,0,2'b00,0,0,0,1,2'b10,ADDI,0,0)});
    if (c == C_BEQ)
      q.push_back('{1'($urandom), zb, 1'b0, ev(ST_E,0,0,0,0,zb,2'b01,0,0,0,1,2'b00,SUB,0,0)});
    if (c == C_LW || c == C_SW) begin
      q.push_back('{1'($urandom), 1'($urandom), 1'b0, ev(ST_E,0,0,0,0,0,2'b00,0,0,0,1,2'b10,ADD,0,0)});
      for (int i = 0; i <= mwait; i++)
        q.push_back('{i == mwait, 1'($urandom), 1'b0, ev(ST_M,1,c == C_SW,1,0,0,2'b00,0,0,0,0,2'b00,ADD,0,0)});
    end
    if (c == C_ADDU || c == C_ADDI || c == C_LW)
      q.push_back('{1'($urandom), 1'($urandom), 1'b0,
                    ev(ST_W,0,0,0,0,0,2'b00,1,c == C_ADDU,c == C_LW,0,2'b00,ADD,0,0)});
    foreach (q[i]) begin
      #1;
      opcode  = q[i].dec ? op : 6'($urandom);
      func    = q[i].dec ? fn : 6'($urandom);
      mem_ack = q[i].ack;
      zero    = q[i].z;
      #1;
      total++;
      if (act !== q[i].e) $display("FAIL %s cyc%0d got=%h exp=%h", name, i, act, q[i].e);
      else passed++;
      @(posedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 mem_ack = 1'b1; opcode = 6'($urandom);
    #1 total++;
    if (act !== 30'd0) $display("FAIL reset_outputs got=%h exp=%h", act, 30'd0);
    else passed++;
    @(posedge clk);
    #1 rst = 1'b0; mem_ack = 1'b0;
    #1 total++;
    if (act !== ev(ST_F,1,0,0,0,0,2'b00,0,0,0,0,2'b01,ADD,0,0))
      $display("FAIL reset_release got=%h exp=%h", act, ev(ST_F,1,0,0,0,0,2'b00,0,0,0,0,2'b01,ADD,0,0));
    else passed++;
    @(posedge clk);
  endtask

  task automatic test_addu();
    run_instr(6'b000000, 6'b100001, 0, 0, 2, "addu");
  endtask

  task automatic test_lw_wait();
    run_instr(6'b100011, 6'($urandom), 0, 3, 2, "lw_wait3");
  endtask

  task automatic test_beq();
    run_instr(6'b000100, 6'($urandom), 0, 0, 1, "beq_z1");
    run_instr(6'b000100, 6'($urandom), 0, 0, 0, "beq_z0");
  endtask

  task automatic test_illegal();
    run_instr(6'b111111, 6'($urandom), 0, 0, 2, "illegal");
    run_instr(6'b000000, 6'b100011, 1, 0, 2, "illegal_func");
  endtask

  task automatic test_back_to_back();
    logic [5:0] op, fn;
    for (int n = 0; n < 30; n++) begin
      fn = 6'($urandom);
      case ($urandom_range(0, 6))
        0: begin op = 6'b000000; fn = 6'b100001; end
        1: op = 6'b001000;
        2: op = 6'b100011;
        3: op = 6'b101011;
        4: op = 6'b000100;
        5: op = 6'b000010;
        default: begin
          do op = 6'($urandom); while (cls_of(op, fn) != C_ILL);
        end
      endcase
      run_instr(op, fn, $urandom_range(0, TO), $urandom_range(0, TO), 2, $sformatf("rand%0d", n));
    end
  endtask

  task automatic test_reset_mid_sw();
    #1 mem_ack = 1'b1;
    @(posedge clk);
    #1 mem_ack = 1'b0; opcode = 6'b101011;
    @(posedge clk);
    #1 opcode = 6'($urandom);
    @(posedge clk);
    #1 mem_ack = 1'b0;
    #1 total++;
    if ({state_o, mem_req, mem_we, mem_iord} !== {ST_M, 3'b111})
      $display("FAIL sw_mem got=%b exp=%b", {state_o, mem_req, mem_we, mem_iord}, {ST_M, 3'b111});
    else passed++;
    #1 rst = 1'b1;
    #1 total++;
    if (act !== 30'd0) $display("FAIL sw_async_reset got=%h exp=%h", act, 30'd0);
    else passed++;
    @(posedge clk);
    #1 rst = 1'b0;
    #1 total++;
    if (act !== ev(ST_F,1,0,0,0,0,2'b00,0,0,0,0,2'b01,ADD,0,0))
      $display("FAIL sw_after_reset got=%h exp=%h", act, ev(ST_F,1,0,0,0,0,2'b00,0,0,0,0,2'b01,ADD,0,0));
    else passed++;
    @(posedge clk);
  endtask

  task automatic test_timeout();
    logic [4:0] exp5;
    #1 rst = 1'b1; mem_ack = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    // Count reaches TO after TO idle cycles; that cycle still sits in FETCH and moves to HALT.
    for (int k = 1; k <= TO + 2; k++) begin
      exp5 = (k <= TO + 1) ? {ST_F, 1'b1, 1'b0} : {ST_H, 1'b0, 1'b1};
      #1 total++;
      if ({state_o, mem_req, bus_err} !== exp5)
        $display("FAIL timeout_cyc%0d got=%b exp=%b", k, {state_o, mem_req, bus_err}, exp5);
      else passed++;
      @(posedge clk);
      #1;
    end
    for (int k = 0; k < 3; k++) begin
      mem_ack = 1'($urandom);
      opcode  = 6'($urandom);
      #1 total++;
      if (act !== ev(ST_H,0,0,0,0,0,2'b00,0,0,0,0,2'b00,ADD,0,1))
        $display("FAIL halt_hold%0d got=%h exp=%h", k, act, ev(ST_H,0,0,0,0,0,2'b00,0,0,0,0,2'b00,ADD,0,1));
      else passed++;
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1 total++;
    if ({state_o, bus_err} !== 4'b0000)
      $display("FAIL halt_reset got=%b exp=%b", {state_o, bus_err}, 4'b0000);
    else passed++;
    @(posedge clk);
    #1 rst = 1'b0; mem_ack = 1'b0;
    #1 total++;
    if (act !== ev(ST_F,1,0,0,0,0,2'b00,0,0,0,0,2'b01,ADD,0,0))
      $display("FAIL halt_release got=%h exp=%h", act, ev(ST_F,1,0,0,0,0,2'b00,0,0,0,0,2'b01,ADD,0,0));
    else passed++;
    @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_addu();
    test_lw_wait();
    test_beq();
    test_illegal();
    test_back_to_back();
    test_reset_mid_sw();
    test_timeout();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
